wb_mtimer: RTL and testbench

- Memory-mapped RISC-V machine timer: a 64-bit free-running `mtime` counter, a 64-bit `mtimecmp` compare register, and a registered machine-timer interrupt.
- Sits downstream of the core's data-side Wishbone interconnect as a pipelined (B4) slave, connected through the `wishbone_if` SLAVE modport.
- Its interrupt output feeds the core's `mip.MTIP` input.

---
 rtl/wb_mtimer_if.sv | 27 ++
 rtl/wb_mtimer.sv | 118 +++++++++++
 tb/tb_wb_mtimer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_mtimer_if.sv
// rtl/wb_mtimer_if.sv - Wishbone B4 pipelined bus interface used by the machine timer
interface wishbone_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [ADDRESS_WIDTH-1:0]  addr;
  logic [DATA_WIDTH/8-1:0]   sel;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      ack;
  logic                      stall;
  logic                      err;
  logic                      rty;

  modport MASTER (
    output cyc, stb, we, addr, sel, wdata,
    input  rdata, ack, stall, err, rty
  );

  modport SLAVE (
    input  cyc, stb, we, addr, sel, wdata,
    output rdata, ack, stall, err, rty
  );
endinterface

// File: rtl/wb_mtimer.sv
// rtl/wb_mtimer.sv - RISC-V machine timer (mtime/mtimecmp) as a pipelined Wishbone slave
module wb_mtimer #(
  parameter int PRESCALE      = 1,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  wishbone_if.SLAVE  wb,
  output logic       timer_int_o
);

  logic                  accept;
  logic                  misaligned;
  logic                  wr_en;
  logic [1:0]            reg_sel;
  logic                  tick;
  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           mtimecmp_q, mtimecmp_d;
  logic [31:0]           rd_mux;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ack_q;
  logic                  err_q;
  logic                  unused_addr;

  // stall is never raised, so every strobe is accepted
  assign accept     = wb.cyc & wb.stb;
  assign misaligned = |wb.addr[1:0];
  assign reg_sel    = wb.addr[3:2];
  assign wr_en      = accept & wb.we & ~misaligned;
  assign unused_addr = ^wb.addr[ADDRESS_WIDTH-1:4];

  if (PRESCALE <= 1) begin : g_noscale
    assign tick = 1'b1;
  end else begin : g_scale
    localparam int PW = $clog2(PRESCALE);
    logic [PW-1:0] pre_q;

    assign tick = (pre_q == PW'(PRESCALE - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        pre_q <= '0;
      end else if (tick) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_q + PW'(1);
      end
    end
  end

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  // A software write to either mtime half wins over the tick and blocks carry
  always_comb begin
    mtime_d = mtime_q;
    if (wr_en && reg_sel == 2'd0) begin
      mtime_d[31:0] = merge_bytes(mtime_q[31:0], wb.wdata, wb.sel);
    end else if (wr_en && reg_sel == 2'd1) begin
      mtime_d[63:32] = merge_bytes(mtime_q[63:32], wb.wdata, wb.sel);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr_en && reg_sel == 2'd2) begin
      mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], wb.wdata, wb.sel);
    end else if (wr_en && reg_sel == 2'd3) begin
      mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wb.wdata, wb.sel);
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (reg_sel)
      2'd0:    rd_mux = mtime_q[31:0];
      2'd1:    rd_mux = mtime_q[63:32];
      2'd2:    rd_mux = mtimecmp_q[31:0];
      default: rd_mux = mtimecmp_q[63:32];
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      timer_int_o <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      ack_q       <= accept & ~misaligned;
      err_q       <= accept & misaligned;
      rdata_q     <= (accept && !wb.we && !misaligned) ? rd_mux : '0;
      timer_int_o <= (mtime_q >= mtimecmp_q);
    end
  end

  // A master that drops cyc has abandoned the cycle; swallow its response
  assign wb.ack   = ack_q & wb.cyc;
  assign wb.err   = err_q & wb.cyc;
  assign wb.rdata = rdata_q;
  assign wb.stall = 1'b0;
  assign wb.rty   = 1'b0;

endmodule

// File: tb/tb_wb_mtimer.sv
// tb/tb_wb_mtimer.sv - directed vector bench for wb_mtimer
module tb_wb_mtimer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rstn2 = 1'b0;
  logic irq1, irq2;
  int   cnt1, cnt2;
  int   nvec = 0;
  int   nfail = 0;

  wishbone_if bus1 ();
  wishbone_if bus2 ();

  wb_mtimer #(.PRESCALE(1)) dut1 (.clk_i(clk), .rstn_i(rstn),  .wb(bus1), .timer_int_o(irq1));
  wb_mtimer #(.PRESCALE(4)) dut2 (.clk_i(clk), .rstn_i(rstn2), .wb(bus2), .timer_int_o(irq2));

  always #5 clk = ~clk;

  // Posedges since reset release equals mtime for PRESCALE=1 absent writes
  always @(posedge clk or negedge rstn)  if (!rstn)  cnt1 <= 0; else cnt1 <= cnt1 + 1;
  always @(posedge clk or negedge rstn2) if (!rstn2) cnt2 <= 0; else cnt2 <= cnt2 + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        exp_ack;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic ack, output logic err);
    bus1.cyc = 1'b1; bus1.stb = 1'b1; bus1.we = we;
    bus1.addr = addr; bus1.sel = sel; bus1.wdata = wd;
    @(posedge clk); #1;
    bus1.stb = 1'b0; bus1.we = 1'b0;
    @(negedge clk);
    rd = bus1.rdata; ack = bus1.ack; err = bus1.err;
  endtask

  logic [31:0] rd;
  logic        ack, err;
  int          snap, rise_k;

  initial begin
    vecs[0]  = '{1'b1, 32'h8,   4'hF, 32'h1122_3344, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'hC,   4'hF, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h8,   4'h5, 32'hAABB_CCDD, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h8,   4'h0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h11BB_33DD};
    vecs[4]  = '{1'b0, 32'hC,   4'h3, 32'h0,         1'b1, 1'b0, 1'b1, 32'h1234_5678};
    vecs[5]  = '{1'b1, 32'hC,   4'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'hC,   4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'h1234_5678};
    vecs[7]  = '{1'b1, 32'hA,   4'hF, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h8,   4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'h11BB_33DD};
    vecs[9]  = '{1'b0, 32'h9,   4'hF, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 32'hC,   4'h8, 32'hFF00_0000, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h10C, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'hFF34_5678};

    bus1.cyc = 0; bus1.stb = 0; bus1.we = 0; bus1.addr = 0; bus1.sel = 0; bus1.wdata = 0;
    bus2.cyc = 0; bus2.stb = 0; bus2.we = 0; bus2.addr = 0; bus2.sel = 0; bus2.wdata = 0;

    repeat (3) @(negedge clk);
    chk("rst_ack",   {31'd0, bus1.ack},   32'd0);
    chk("rst_err",   {31'd0, bus1.err},   32'd0);
    chk("rst_rdata", bus1.rdata,          32'd0);
    chk("rst_stall", {31'd0, bus1.stall}, 32'd0);
    chk("rst_rty",   {31'd0, bus1.rty},   32'd0);
    chk("rst_irq",   {31'd0, irq1},       32'd0);
    rstn = 1'b1;

    xfer(1'b0, 32'h8, 4'hF, 32'h0, rd, ack, err);
    chk("cmp_lo_rst", rd, 32'hFFFF_FFFF);
    chk("cmp_lo_ack", {31'd0, ack}, 32'd1);
    xfer(1'b0, 32'hC, 4'hF, 32'h0, rd, ack, err);
    chk("cmp_hi_rst", rd, 32'hFFFF_FFFF);
    chk("irq_idle", {31'd0, irq1}, 32'd0);
    repeat (5) @(negedge clk);
    snap = cnt1;
    xfer(1'b0, 32'h0, 4'hF, 32'h0, rd, ack, err);
    chk("mtime_count", rd, snap);

    for (int i = 0; i < 12; i++) begin
      xfer(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata, rd, ack, err);
      chk($sformatf("vec%0d_ack", i), {31'd0, ack}, {31'd0, vecs[i].exp_ack});
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Four back-to-back requests with stb held high
    snap = cnt1;
    bus1.cyc = 1; bus1.stb = 1; bus1.we = 0; bus1.addr = 32'h0; bus1.sel = 4'hF;
    @(posedge clk); #1;
    bus1.we = 1; bus1.addr = 32'h8; bus1.wdata = 32'h0000_5A5A;
    @(negedge clk);
    chk("pipe0_ack", {31'd0, bus1.ack}, 32'd1);
    chk("pipe0_rd", bus1.rdata, snap);
    chk("pipe_stall", {31'd0, bus1.stall}, 32'd0);
    @(posedge clk); #1;
    bus1.we = 1; bus1.addr = 32'h6; bus1.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("pipe1_ack", {31'd0, bus1.ack}, 32'd1);
    chk("pipe1_err", {31'd0, bus1.err}, 32'd0);
    @(posedge clk); #1;
    bus1.we = 0; bus1.addr = 32'h8;
    @(negedge clk);
    chk("pipe2_ack", {31'd0, bus1.ack}, 32'd0);
    chk("pipe2_err", {31'd0, bus1.err}, 32'd1);
    chk("pipe2_rd", bus1.rdata, 32'd0);
    @(posedge clk); #1;
    bus1.stb = 0;
    @(negedge clk);
    chk("pipe3_ack", {31'd0, bus1.ack}, 32'd1);
    chk("pipe3_rd", bus1.rdata, 32'h0000_5A5A);
    xfer(1'b0, 32'h4, 4'hF, 32'h0, rd, ack, err);
    chk("misalign_nochg", rd, 32'd0);

    // Abort: cyc dropped in the response cycle
    bus1.cyc = 1; bus1.stb = 1; bus1.we = 1; bus1.addr = 32'h8; bus1.sel = 4'hF; bus1.wdata = 32'h77;
    @(posedge clk); #1;
    bus1.stb = 0; bus1.we = 0; bus1.cyc = 0;
    @(negedge clk);
    chk("abort_ack", {31'd0, bus1.ack}, 32'd0);
    xfer(1'b0, 32'h8, 4'hF, 32'h0, rd, ack, err);
    chk("abort_commit", rd, 32'h77);

    xfer(1'b1, 32'h0, 4'hF, 32'h100, rd, ack, err);
    xfer(1'b0, 32'h0, 4'hF, 32'h0, rd, ack, err);
    chk("prio_noinc", rd, 32'h100);
    xfer(1'b0, 32'h0, 4'hF, 32'h0, rd, ack, err);
    chk("prio_next", rd, 32'h101);

    // Interrupt: mtime := 0 at edge e0, so mtime hits 20 at e0+20, irq at e0+21
    xfer(1'b1, 32'h0, 4'hF, 32'd0, rd, ack, err);
    xfer(1'b1, 32'h8, 4'hF, 32'd20, rd, ack, err);
    xfer(1'b1, 32'hC, 4'hF, 32'd0, rd, ack, err);
    rise_k = 99;
    for (int k = 2; k < 60; k++) begin
      if (irq1) begin
        rise_k = k;
        break;
      end
      @(negedge clk);
    end
    chk("irq_rise_cycle", rise_k, 21);
    xfer(1'b1, 32'hC, 4'hF, 32'd1, rd, ack, err);
    chk("irq_hold", {31'd0, irq1}, 32'd1);
    @(negedge clk);
    chk("irq_fall", {31'd0, irq1}, 32'd0);

    xfer(1'b1, 32'h0, 4'hF, 32'hFFFF_FFFE, rd, ack, err);
    xfer(1'b1, 32'h4, 4'hF, 32'hFFFF_FFFF, rd, ack, err);
    xfer(1'b0, 32'h0, 4'hF, 32'h0, rd, ack, err);
    chk("wrap_lo0", rd, 32'hFFFF_FFFE);
    xfer(1'b0, 32'h4, 4'hF, 32'h0, rd, ack, err);
    chk("wrap_hi0", rd, 32'hFFFF_FFFF);
    xfer(1'b0, 32'h0, 4'hF, 32'h0, rd, ack, err);
    chk("wrap_lo1", rd, 32'd0);
    xfer(1'b0, 32'h4, 4'hF, 32'h0, rd, ack, err);
    chk("wrap_hi1", rd, 32'd0);

    // Asynchronous reset between acceptance and response
    bus1.cyc = 1; bus1.stb = 1; bus1.we = 1; bus1.addr = 32'h8; bus1.sel = 4'hF; bus1.wdata = 32'h5;
    @(posedge clk); #1;
    bus1.stb = 0; bus1.we = 0;
    rstn = 1'b0;
    #1;
    chk("rst_mid_ack", {31'd0, bus1.ack}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    xfer(1'b0, 32'h8, 4'hF, 32'h0, rd, ack, err);
    chk("rst_mid_cmp", rd, 32'hFFFF_FFFF);

    // PRESCALE=4: read accepted after s posedges since release returns s/4
    @(negedge clk);
    rstn2 = 1'b1;
    for (int t = 0; t < 200 && cnt2 < 99; t++) @(negedge clk);
    chk("pre_sync", cnt2, 99);
    bus2.cyc = 1; bus2.stb = 1; bus2.we = 0; bus2.addr = 32'h0; bus2.sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      if (i == 5) begin
        #1;
        bus2.stb = 0;
      end
      @(negedge clk);
      chk($sformatf("pre_rd%0d", i), bus2.rdata, (99 + i) / 4);
    end
    bus2.cyc = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
